// File: rtl/uart_loopback_top.sv
// 8N1 UART transmitter and receiver with the TX line looped back internally to the RX input.
// Both bit timers are down-counters that reload on terminal count.
//
// state   | meaning (TX / RX)
// S_IDLE  | line idle high; TX waits for tx_start, RX waits for a low line
// S_START | start bit; TX drives 0, RX confirms the start bit at mid-bit
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit; TX pulses tx_done at its end, RX checks for 1 and posts the byte
module uart_loopback_top #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       tx_done,
    output logic       rx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          tx_state, tx_next;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_tc;
    logic            tx_line;

    state_t          rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tc;
    logic            rx_sync1, rx_sync2;
    logic            rx_done_q;

    assign tx_tc = (tx_cnt == '0);
    assign rx_tc = (rx_cnt == '0);

    // ---------------- transmitter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            case (tx_state)
                S_IDLE: begin
                    if (tx_start) begin
                        tx_shift <= tx_data;
                        tx_cnt   <= BIT_LOAD;
                        tx_bit   <= '0;
                    end
                end
                S_START: tx_cnt <= tx_tc ? BIT_LOAD : tx_cnt - 1'b1;
                S_DATA: begin
                    if (tx_tc) begin
                        tx_cnt   <= BIT_LOAD;
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_STOP: if (!tx_tc) tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_start) tx_next = S_START;
            S_START: if (tx_tc) tx_next = S_DATA;
            S_DATA:  if (tx_tc && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tc) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift[0];
            default: tx_line = 1'b1;
        endcase
        tx_done = (tx_state == S_STOP) && tx_tc && !rst;
    end

    // ---------------- receiver ----------------
    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1  <= 1'b1;
            rx_sync2  <= 1'b1;
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_sync1  <= tx_line;
            rx_sync2  <= rx_sync1;
            rx_state  <= rx_next;
            rx_done_q <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (!rx_sync2) begin
                        rx_cnt <= HALF_LOAD;
                        rx_bit <= '0;
                    end
                end
                S_START: rx_cnt <= rx_tc ? BIT_LOAD : rx_cnt - 1'b1;
                S_DATA: begin
                    if (rx_tc) begin
                        rx_cnt   <= BIT_LOAD;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_tc) begin
                        if (rx_sync2) begin
                            rx_data   <= rx_shift;
                            rx_done_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rx_sync2) rx_next = S_START;
            S_START: if (rx_tc) rx_next = rx_sync2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tc && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tc) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_done = rx_done_q && !rst;
    end

endmodule

// File: tb/tb_uart_loopback_top.sv
// Scoreboarded bench for uart_loopback_top: stimulus pushes expected bytes, a
// monitor pops and compares on every rx_done pulse.
module tb_uart_loopback_top;
    localparam int CPB = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       rx_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int rx_cnt = 0;
    int last_tx_cyc = 0;
    int last_rx_cyc = 0;
    logic tx_done_d = 1'b0;
    logic rx_done_d = 1'b0;
    logic [7:0] exp_q[$];

    uart_loopback_top dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .tx_done (tx_done),
        .rx_done (rx_done)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) check("done_during_reset", int'({tx_done, rx_done}), 0);
        if (tx_done) begin
            tx_cnt++;
            last_tx_cyc = cyc;
            check("tx_done_single_cycle", int'(tx_done_d), 0);
        end
        if (rx_done) begin
            rx_cnt++;
            last_rx_cyc = cyc;
            check("rx_done_single_cycle", int'(rx_done_d), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got 0x%0h expected no frame", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rx_data", int'(rx_data), int'(e));
            end
        end
        tx_done_d = tx_done;
        rx_done_d = rx_done;
    end

    task automatic send(input logic [7:0] b, output int acc);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        int n = 0;
        while (tx_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, int'(tx_cnt >= target), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int t0, r0;
        logic [9:0] frame;
        logic [7:0] b;

        // 1. reset
        repeat (5) @(negedge clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_tx_done", int'(tx_done), 0);
        check("reset_rx_done", int'(rx_done), 0);
        check("reset_line", int'(dut.tx_line), 1);
        #1 rst = 1'b0;

        // 2. 0x55 with line waveform and latency
        b = 8'h55;
        frame = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        acc = cyc;
        repeat (CPB / 2) @(negedge clk);
        check("line_bit0", int'(dut.tx_line), int'(frame[0]));
        for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(negedge clk);
            check($sformatf("line_bit%0d", k), int'(dut.tx_line), int'(frame[k]));
        end
        wait_tx(1, 2 * CPB, "tx_done_55_seen");
        check("tx_done_latency", last_tx_cyc - acc, 10 * CPB - 1);
        check("rx_count_55", rx_cnt, 1);
        check("rx_before_tx", int'(last_rx_cyc < last_tx_cyc), 1);
        check("rx_latency_window",
              int'((last_rx_cyc - acc) >= (19 * CPB) / 2 && (last_rx_cyc - acc) <= (19 * CPB) / 2 + 8), 1);

        // 3. 0x00 then 0xFF back to back
        t0 = tx_cnt; r0 = rx_cnt;
        exp_q.push_back(8'h00);
        send(8'h00, acc);
        wait_tx(t0 + 1, 11 * CPB, "tx_done_00_seen");
        exp_q.push_back(8'hFF);
        send(8'hFF, acc);
        wait_tx(t0 + 2, 11 * CPB, "tx_done_ff_seen");
        check("tx_done_ff_latency", last_tx_cyc - acc, 10 * CPB - 1);
        check("rx_count_00_ff", rx_cnt - r0, 2);
        check("rx_data_ff", int'(rx_data), 8'hFF);

        // 4. 0xA3 with a mid-frame request for 0x3C that must be ignored
        t0 = tx_cnt; r0 = rx_cnt;
        exp_q.push_back(8'hA3);
        send(8'hA3, acc);
        repeat (1000) @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_tx(t0 + 1, 11 * CPB, "tx_done_a3_seen");
        idle(12 * CPB);
        check("midframe_tx_count", tx_cnt - t0, 1);
        check("midframe_rx_count", rx_cnt - r0, 1);
        check("rx_data_a3", int'(rx_data), 8'hA3);

        // 5. 0xC5 aborted by reset during data bit 4, then 0x5A
        t0 = tx_cnt; r0 = rx_cnt;
        send(8'hC5, acc);
        repeat (5 * CPB + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_rx_data", int'(rx_data), 0);
        check("abort_line", int'(dut.tx_line), 1);
        idle(12 * CPB);
        check("abort_tx_count", tx_cnt - t0, 0);
        check("abort_rx_count", rx_cnt - r0, 0);
        exp_q.push_back(8'h5A);
        send(8'h5A, acc);
        wait_tx(t0 + 1, 11 * CPB, "tx_done_5a_seen");
        check("rx_count_5a", rx_cnt - r0, 1);
        check("rx_data_5a", int'(rx_data), 8'h5A);

        // 6. tx_start held high: back-to-back 0x81 frames
        t0 = tx_cnt; r0 = rx_cnt;
        repeat (3) exp_q.push_back(8'h81);
        @(negedge clk);
        tx_data  = 8'h81;
        tx_start = 1'b1;
        wait_tx(t0 + 3, 33 * CPB, "tx_done_81_x3_seen");
        tx_start = 1'b0;
        idle(12 * CPB);
        check("b2b_tx_count", tx_cnt - t0, 3);
        check("b2b_rx_count", rx_cnt - r0, 3);
        check("b2b_tx_eq_rx", tx_cnt - t0, rx_cnt - r0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
